// File: rtl/gate_response_checker.sv
//------------------------------------------------------------------------------
// gate_response_checker
//   Drives all four input vectors into a two-input gate and checks its output
//   against the truth table of the selected function; reports pass/fail,
//   a saturating error count and a per-vector failure map.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gate_response_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ROUNDS        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             dut_out,
  output logic             stim_in1,
  output logic             stim_in2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       ROUND_LAST  = 8'(ROUNDS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       round_q, round_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;

  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  function automatic logic expected_out(input logic [2:0] sel, input logic a, input logic b);
    logic y;
    case (sel)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = ~(a & b);
      3'd3:    y = ~(a | b);
      3'd4:    y = a ^ b;
      3'd5:    y = ~(a ^ b);
      3'd6:    y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    round_d  = round_q;
    cnt_d    = cnt_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mismatch = 1'b0;
    err_next = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d   = gate_sel;
          err_d   = '0;
          fail_d  = 4'b0000;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          round_d = 8'd0;
          busy_d  = 1'b1;
          state_d = S_APPLY;
        end
      end

      S_APPLY: begin
        stim_d = idx_q;
        if (SETTLE_CYCLES > 0) begin
          cnt_d   = SETTLE_LAST;
          state_d = S_SETTLE;
        end else begin
          state_d = S_SAMPLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_SAMPLE: begin
        mismatch = (dut_out != expected_out(sel_q, stim_q[1], stim_q[0]));
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_next = err_q + ERR_W'(1);
          end
          fail_d[idx_q] = 1'b1;
        end
        err_d = err_next;

        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_APPLY;
        end else if (round_q != ROUND_LAST) begin
          round_d = round_q + 8'd1;
          idx_d   = 2'd0;
          state_d = S_APPLY;
        end else begin
          // Verdict must include the sample taken on this very cycle.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_next == '0);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      idx_q   <= 2'd0;
      round_q <= 8'd0;
      cnt_q   <= 8'd0;
      stim_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign stim_in1  = stim_q[1];
  assign stim_in2  = stim_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_response_checker.sv
// Testbench for gate_response_checker: three instances with different settle/round/width
// parameters, driven by a truth-table reference model of the gate under test.
`default_nettype none

module tb_gate_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] gate_sel;
  logic       start_v   [3];
  logic       dut_out_v [3];
  logic       stim1_v   [3];
  logic       stim2_v   [3];
  logic       busy_v    [3];
  logic       done_v    [3];
  logic       pass_v    [3];
  logic [3:0] fail_v    [3];
  logic [3:0] err_a, err_b;
  logic [1:0] err_c;

  int         mode_v [3];
  logic [2:0] msel_v [3];

  // Per-instance parameters: settle cycles, rounds, saturation ceiling.
  int s_p    [3] = '{2, 2, 0};
  int r_p    [3] = '{1, 5, 2};
  int emax_p [3] = '{15, 15, 3};

  int checks = 0;
  int errors = 0;

  int         obs_done_cyc, obs_stim_bad, obs_busy_bad, obs_err;
  logic       obs_pass;
  logic [3:0] obs_fail;

  always #5 clk = ~clk;

  gate_response_checker #(.SETTLE_CYCLES(2), .ROUNDS(1), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .gate_sel(gate_sel), .dut_out(dut_out_v[0]),
    .stim_in1(stim1_v[0]), .stim_in2(stim2_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_a), .fail_vec(fail_v[0]));

  gate_response_checker #(.SETTLE_CYCLES(2), .ROUNDS(5), .ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .gate_sel(gate_sel), .dut_out(dut_out_v[1]),
    .stim_in1(stim1_v[1]), .stim_in2(stim2_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_b), .fail_vec(fail_v[1]));

  gate_response_checker #(.SETTLE_CYCLES(0), .ROUNDS(2), .ERR_W(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .gate_sel(gate_sel), .dut_out(dut_out_v[2]),
    .stim_in1(stim1_v[2]), .stim_in2(stim2_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_c), .fail_vec(fail_v[2]));

  // Truth table column per function, bit k = output for {in1,in2}=k.
  function automatic logic [3:0] tt_of(input logic [2:0] s);
    case (s)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b0111;
      3'd3:    return 4'b0001;
      3'd4:    return 4'b0110;
      3'd5:    return 4'b1001;
      3'd6:    return 4'b0011;
      default: return 4'b1100;
    endcase
  endfunction

  // Gate-under-test model: 0 correct gate msel, 1 stuck at 0, 2 inverted gate msel.
  function automatic logic model_out(input int mode, input logic [2:0] msel, input logic [1:0] v);
    logic [3:0] t;
    t = tt_of(msel);
    if (mode == 0) return t[v];
    if (mode == 1) return 1'b0;
    return ~t[v];
  endfunction

  function automatic int err_of(input int i);
    if (i == 0) return int'(err_a);
    if (i == 1) return int'(err_b);
    return int'(err_c);
  endfunction

  always_comb begin
    dut_out_v[0] = model_out(mode_v[0], msel_v[0], {stim1_v[0], stim2_v[0]});
    dut_out_v[1] = model_out(mode_v[1], msel_v[1], {stim1_v[1], stim2_v[1]});
    dut_out_v[2] = model_out(mode_v[2], msel_v[2], {stim1_v[2], stim2_v[2]});
  end

  task automatic expect_run(input int i, input logic [2:0] sel, input int mode, input logic [2:0] msel,
                            output int e_err, output logic [3:0] e_fail, output int e_cyc);
    logic [3:0] t;
    int mism;
    t = tt_of(sel);
    mism = 0;
    e_fail = 4'b0000;
    for (int v = 0; v < 4; v++) begin
      if (model_out(mode, msel, 2'(v)) !== t[v]) begin
        mism++;
        e_fail[v] = 1'b1;
      end
    end
    e_err = r_p[i] * mism;
    if (e_err > emax_p[i]) e_err = emax_p[i];
    e_cyc = r_p[i] * 4 * (s_p[i] + 2);
  endtask

  // One complete run on instance i; records what was observed, compares nothing.
  task automatic run(input int i, input logic [2:0] sel, input int mode, input logic [2:0] msel, input bit poke);
    int lim;
    lim = r_p[i] * 4 * (s_p[i] + 2) + 20;
    mode_v[i] = mode;
    msel_v[i] = msel;
    @(negedge clk);
    gate_sel = sel;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    obs_done_cyc = -1;
    obs_stim_bad = 0;
    obs_busy_bad = (busy_v[i] !== 1'b1) ? 1 : 0;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (done_v[i] === 1'b1) begin
        obs_done_cyc = c;
        if (busy_v[i] !== 1'b0) obs_busy_bad++;
        break;
      end
      if (busy_v[i] !== 1'b1) obs_busy_bad++;
      if ((c - 1) % (s_p[i] + 2) == 0 &&
          {stim1_v[i], stim2_v[i]} !== 2'(((c - 1) / (s_p[i] + 2)) % 4)) obs_stim_bad++;
      if (poke && c == 3) begin
        start_v[i] = 1'b1;
        gate_sel = sel ^ 3'b111;
      end
      if (poke && c == 5) start_v[i] = 1'b0;
    end
    obs_pass = pass_v[i];
    obs_err  = err_of(i);
    obs_fail = fail_v[i];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({stim1_v[i], stim2_v[i], busy_v[i], done_v[i], pass_v[i], fail_v[i]} !== 9'd0 || err_of(i) != 0) begin
        errors++;
        $display("FAIL reset_state inst%0d: stim=%b%b busy=%b done=%b pass=%b err=%0d fail=%b, want all 0",
                 i, stim1_v[i], stim2_v[i], busy_v[i], done_v[i], pass_v[i], err_of(i), fail_v[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_xnor_correct();
    run(0, 3'd5, 0, 3'd5, 1'b0);
    checks++; if (obs_done_cyc != 16) begin errors++; $display("FAIL xnor_done_cycle: got %0d want 16", obs_done_cyc); end
    checks++; if (obs_stim_bad + obs_busy_bad != 0) begin errors++; $display("FAIL xnor_sequence: stim errs %0d busy errs %0d want 0", obs_stim_bad, obs_busy_bad); end
    checks++; if (obs_pass !== 1'b1 || obs_err != 0 || obs_fail !== 4'b0000) begin errors++; $display("FAIL xnor_result: pass=%b err=%0d fail=%b want 1/0/0000", obs_pass, obs_err, obs_fail); end
  endtask

  task automatic test_tied_zero();
    run(0, 3'd5, 1, 3'd0, 1'b0);
    checks++; if (obs_err != 2) begin errors++; $display("FAIL tied0_err: got %0d want 2", obs_err); end
    checks++; if (obs_fail !== 4'b1001 || obs_pass !== 1'b0) begin errors++; $display("FAIL tied0_fail: fail=%b pass=%b want 1001/0", obs_fail, obs_pass); end
    repeat (3) @(negedge clk);
    checks++;
    if (err_a !== 4'd2 || fail_v[0] !== 4'b1001 || done_v[0] !== 1'b0 || {stim1_v[0], stim2_v[0]} !== 2'b11) begin
      errors++;
      $display("FAIL tied0_hold: err=%0d fail=%b done=%b stim=%b%b want 2/1001/0/11", err_a, fail_v[0], done_v[0], stim1_v[0], stim2_v[0]);
    end
  endtask

  task automatic test_xor_vs_xnor();
    run(0, 3'd5, 0, 3'd4, 1'b0);
    checks++; if (obs_err != 4 || obs_fail !== 4'b1111 || obs_pass !== 1'b0) begin errors++; $display("FAIL xor_as_xnor: err=%0d fail=%b pass=%b want 4/1111/0", obs_err, obs_fail, obs_pass); end
    run(0, 3'd4, 0, 3'd4, 1'b0);
    checks++; if (obs_err != 0 || obs_fail !== 4'b0000 || obs_pass !== 1'b1) begin errors++; $display("FAIL xor_as_xor: err=%0d fail=%b pass=%b want 0/0000/1", obs_err, obs_fail, obs_pass); end
  endtask

  task automatic test_saturation();
    run(1, 3'd5, 2, 3'd5, 1'b0);
    checks++; if (obs_err != 15 || obs_fail !== 4'b1111 || obs_pass !== 1'b0) begin errors++; $display("FAIL sat_result: err=%0d fail=%b pass=%b want 15/1111/0", obs_err, obs_fail, obs_pass); end
    checks++; if (obs_done_cyc != 80 || obs_stim_bad + obs_busy_bad != 0) begin errors++; $display("FAIL sat_timing: done at %0d (want 80), seq errs %0d", obs_done_cyc, obs_stim_bad + obs_busy_bad); end
    run(2, 3'd5, 1, 3'd0, 1'b0);
    checks++; if (obs_err != 3 || obs_fail !== 4'b1001 || obs_done_cyc != 16) begin errors++; $display("FAIL sat_narrow: err=%0d fail=%b done=%0d want 3/1001/16", obs_err, obs_fail, obs_done_cyc); end
    checks++; if (obs_stim_bad + obs_busy_bad != 0) begin errors++; $display("FAIL zero_settle_sequence: errs %0d want 0", obs_stim_bad + obs_busy_bad); end
  endtask

  task automatic test_start_during_busy();
    run(0, 3'd5, 0, 3'd5, 1'b1);
    checks++; if (obs_done_cyc != 16 || obs_stim_bad + obs_busy_bad != 0) begin errors++; $display("FAIL busy_start_timing: done at %0d (want 16), seq errs %0d", obs_done_cyc, obs_stim_bad + obs_busy_bad); end
    checks++; if (obs_pass !== 1'b1 || obs_err != 0) begin errors++; $display("FAIL busy_start_result: pass=%b err=%0d want 1/0", obs_pass, obs_err); end
  endtask

  task automatic test_mid_run_reset();
    int spurious;
    mode_v[0] = 1;
    @(negedge clk);
    gate_sel = 3'd5;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (err_a !== 4'd1 || busy_v[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_state: err=%0d busy=%b want 1/1", err_a, busy_v[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0 || {stim1_v[0], stim2_v[0]} !== 2'b00 || err_a !== 4'd0 || fail_v[0] !== 4'b0000 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: busy=%b stim=%b%b err=%0d fail=%b done=%b want 0/00/0/0000/0",
               busy_v[0], stim1_v[0], stim2_v[0], err_a, fail_v[0], done_v[0]);
    end
    spurious = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL mid_reset_quiet: %0d active cycles want 0", spurious); end
    run(0, 3'd5, 0, 3'd5, 1'b0);
    checks++; if (obs_pass !== 1'b1 || obs_err != 0 || obs_done_cyc != 16) begin errors++; $display("FAIL post_reset_run: pass=%b err=%0d done=%0d want 1/0/16", obs_pass, obs_err, obs_done_cyc); end
  endtask

  task automatic test_back_to_back();
    int   dq[$];
    logic b17, b18;
    mode_v[2] = 0;
    msel_v[2] = 3'd1;
    b17 = 1'bx;
    b18 = 1'bx;
    @(negedge clk);
    gate_sel = 3'd1;
    start_v[2] = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done_v[2] === 1'b1) dq.push_back(c);
      if (c == 17) b17 = busy_v[2];
      if (c == 18) begin
        b18 = busy_v[2];
        start_v[2] = 1'b0;
      end
    end
    checks++; if (dq.size() != 2 || dq[0] != 16 || dq[1] != 34) begin errors++; $display("FAIL b2b_done_pulses: count %0d first %0d second %0d want 2/16/34", dq.size(), dq[0], dq[1]); end
    checks++; if (b17 !== 1'b0 || b18 !== 1'b1 || pass_v[2] !== 1'b1) begin errors++; $display("FAIL b2b_busy: busy17=%b busy18=%b pass=%b want 0/1/1", b17, b18, pass_v[2]); end
  endtask

  task automatic test_random();
    int i, mode, e_err, e_cyc;
    logic [2:0] sel, msel;
    logic [3:0] e_fail;
    for (int k = 0; k < 12; k++) begin
      i    = $urandom_range(0, 2);
      sel  = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 2);
      msel = ($urandom_range(0, 1) == 0) ? sel : 3'($urandom_range(0, 7));
      run(i, sel, mode, msel, 1'($urandom_range(0, 1)));
      expect_run(i, sel, mode, msel, e_err, e_fail, e_cyc);
      checks++; if (obs_err != e_err || obs_fail !== e_fail) begin errors++; $display("FAIL rand%0d_result inst%0d sel=%0d: err=%0d fail=%b want %0d/%b", k, i, sel, obs_err, obs_fail, e_err, e_fail); end
      checks++; if (obs_pass !== (e_fail == 4'b0000)) begin errors++; $display("FAIL rand%0d_pass inst%0d: got %b want %b", k, i, obs_pass, e_fail == 4'b0000); end
      checks++; if (obs_done_cyc != e_cyc || obs_stim_bad + obs_busy_bad != 0) begin errors++; $display("FAIL rand%0d_timing inst%0d: done at %0d want %0d, seq errs %0d", k, i, obs_done_cyc, e_cyc, obs_stim_bad + obs_busy_bad); end
    end
  endtask

  initial begin
    rst = 1'b1;
    gate_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 0;
      msel_v[i]  = 3'd0;
    end
    test_reset();
    test_xnor_correct();
    test_tied_zero();
    test_xor_vs_xnor();
    test_saturation();
    test_start_during_busy();
    test_mid_run_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
Synthesizable self-checking stimulus/response engine for the NAND-derived basic-gate library. It is the checking end of the gate test flow: it drives the two gate inputs through all four input vectors and samples the gate-under-test output. It compares each sample against the truth table of the selected gate, then reports pass/fail, an error count and the failing vectors. It sits beside a gate instance in on-chip or FPGA self-test wrappers, replacing hand-driven stimulus with a start/done handshake.

Parameters:
SETTLE_CYCLES, 2, number of wait cycles between driving a vector and sampling dut_out (legal range 0..255)
ROUNDS, 1, number of full 4-vector sweeps per run (legal range 1..255)
ERR_W, 4, width of err_count

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  run request, sampled in IDLE only
gate_sel  input  3  expected function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(in1), 7 BUF(in1)
dut_out  input  1  output of the gate under test
stim_in1  output  1  gate input 1, registered
stim_in2  output  1  gate input 2, registered
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at end of run
pass  output  1  1 when the last run had err_count==0; valid while done or after it
err_count  output  ERR_W  mismatches in the last run, saturating
fail_vec  output  4  bit k set if vector k ({in1,in2}=k) mismatched in any round

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates occur on the rising edge of clk.
- Reset values: state=IDLE, stim_in1=0, stim_in2=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0. rst overrides all other inputs.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE -> APPLY on start=1:
  - latch gate_sel; clear err_count, fail_vec and pass; set vector index=0 and round=0; set busy=1.
- APPLY (1 cycle):
  - {stim_in1,stim_in2} <= vector index. Vector order is 00, 01, 10, 11.
  - Go to SETTLE if SETTLE_CYCLES>0, else to SAMPLE.
- SETTLE (exactly SETTLE_CYCLES cycles, internal down-counter) -> SAMPLE.
- SAMPLE (1 cycle): compare dut_out with expected(latched gate_sel, stim_in1, stim_in2). On mismatch:
  - err_count increments, saturating at 2^ERR_W-1;
  - fail_vec[index] <= 1.
- SAMPLE exit:
  - If index<3: index++ and go to APPLY.
  - Else if round<ROUNDS-1: round++, index=0 and go to APPLY.
  - Else go to DONE.
- DONE (1 cycle):
  - done=1, busy=0, pass=(err_count==0) including the final SAMPLE result; next state IDLE.
- Stimulus holds its last value (11) in IDLE after a run.
- Results (pass, err_count, fail_vec) hold until the next accepted start.
- Per-vector time is SETTLE_CYCLES+2 cycles. done asserts ROUNDS*4*(SETTLE_CYCLES+2) cycles after the start-accept edge.
- start is ignored while busy or in DONE. A start held high in IDLE after DONE begins a new run immediately.
- gate_sel changes during a run have no effect.
- rst asserted mid-run aborts the run and returns everything to reset values on that edge. No done pulse is generated.
- NOT/BUF codes ignore stim_in2 for the expected value; all four vectors are still applied.

Test Plan:
- Correct XNOR model on dut_out, gate_sel=5, SETTLE_CYCLES=2, ROUNDS=1, start pulse -> stimulus sequence 00,01,10,11. done pulses 16 cycles after accept; pass=1, err_count=0, fail_vec=0000.
- dut_out tied 0, gate_sel=5 -> err_count=2, fail_vec=1001, pass=0.
- dut_out driven by a correct XOR while gate_sel=5 -> err_count=4, fail_vec=1111, pass=0. The same XOR model with gate_sel=4 -> pass=1.
- Inverted-XNOR model, ROUNDS=5, ERR_W=4 -> 20 mismatches saturate at err_count=15; fail_vec=1111; done pulses at cycle 80.
- start pulsed during busy and gate_sel changed mid-run -> no restart. The result reflects the original gate_sel and done timing is unchanged.
- rst asserted at cycle 7 of a run -> next edge busy=0, stim=00, err_count=0. No done pulse; a following start runs cleanly to pass=1.
